// File: rtl/anton_neopixel_stream_ctrl.sv
// anton_neopixel_stream_ctrl
//   Streams the pixel buffer held in anton_neopixel_registers out as a WS2812
//   bit stream. Bytes are read over a 1-cycle-latency port, shifted out MSB
//   first with NeoPixel high/low timing, and the frame is closed with a low
//   latch period. A one-cycle stream_sync_of pulse marks a completed frame.
//
// Ports
//   busClk, busReset          clock, synchronous active-high reset
//   reg_max                   last byte index when reg_ctrl_limit is set
//   reg_ctrl_run              start / keep streaming; dropping it aborts the frame
//   reg_ctrl_limit            use min(reg_max, BUFFER_END) as the last index
//   reg_ctrl_32bit            4 bytes per pixel, byte 3 of each group skipped
//   rdAddr, rdEn, rdData      pixel-buffer read port (data valid cycle after rdEn)
//   neoData                   serial LED line
//   stream_sync_of            1-cycle pulse in DONE after a completed frame
//   state                     1 while busy (not IDLE / DONE)
//   frameCount                completed-frame counter (optional)
//
// Optional feature
//   ANTON_NEOPIXEL_STREAM_FRAME_COUNT_EN adds the frameCount[15:0] output.

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 511
`endif

module anton_neopixel_stream_ctrl #(
    parameter int BUFFER_END   = `BUFFER_END_DEFAULT,
    parameter int CYCLES_T0H   = 20,
    parameter int CYCLES_T1H   = 40,
    parameter int CYCLES_BIT   = 63,
    parameter int CYCLES_RESET = 2500,
    localparam int AW = (BUFFER_END < 1) ? 1 : $clog2(BUFFER_END + 1)
) (
    input  logic          busClk,
    input  logic          busReset,
    input  logic [12:0]   reg_max,
    input  logic          reg_ctrl_run,
    input  logic          reg_ctrl_limit,
    input  logic          reg_ctrl_32bit,
    output logic [AW-1:0] rdAddr,
    output logic          rdEn,
    input  logic [7:0]    rdData,
    output logic          neoData,
    output logic          stream_sync_of,
    output logic          state
`ifdef ANTON_NEOPIXEL_STREAM_FRAME_COUNT_EN
    ,
    output logic [15:0]   frameCount
`endif
);

    // One counter serves both bit timing and the latch period.
    localparam int CMAX = (CYCLES_RESET > CYCLES_BIT) ? CYCLES_RESET : CYCLES_BIT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] BIT_LAST = CW'(CYCLES_BIT - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(CYCLES_RESET - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(CYCLES_T0H);
    localparam logic [CW-1:0] T1H_C    = CW'(CYCLES_T1H);
    localparam logic [13:0]   BE14     = 14'(BUFFER_END);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_BIT, S_LATCH, S_DONE
    } fsm_t;

    fsm_t          fsm;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] cnt;
    logic [13:0]   last_idx;   // frame-constant last byte index
    logic          mode32;     // frame-constant 32-bit layout flag
    logic          stop_req;   // run seen low at some point in this bit/fetch
    logic          aborted;
    logic          dead;       // blocks run sampling in the first IDLE after DONE

    logic [13:0]   cur_addr;
    logic [13:0]   next_addr;
    logic [13:0]   max_ext;
    logic [13:0]   last_sel;
    logic [CW-1:0] th_cur;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        cur_addr  = 14'(rdAddr);
        // In 32-bit mode byte 2 of a group jumps over channel 3.
        next_addr = cur_addr + ((mode32 && cur_addr[1:0] == 2'd2) ? 14'd2 : 14'd1);
        max_ext   = {1'b0, reg_max};
        last_sel  = (reg_ctrl_limit && (max_ext < BE14)) ? max_ext : BE14;
        th_cur    = shreg[7] ? T1H_C : T0H_C;
        cnt_inc   = cnt + 1'b1;
    end

    always_ff @(posedge busClk) begin
        if (busReset) begin
            fsm            <= S_IDLE;
            rdAddr         <= '0;
            rdEn           <= 1'b0;
            neoData        <= 1'b0;
            stream_sync_of <= 1'b0;
            state          <= 1'b0;
            shreg          <= '0;
            bit_cnt        <= '0;
            cnt            <= '0;
            last_idx       <= '0;
            mode32         <= 1'b0;
            stop_req       <= 1'b0;
            aborted        <= 1'b0;
            dead           <= 1'b0;
`ifdef ANTON_NEOPIXEL_STREAM_FRAME_COUNT_EN
            frameCount     <= '0;
`endif
        end else begin
            rdEn           <= 1'b0;
            stream_sync_of <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (dead) begin
                        dead <= 1'b0;
                    end else if (reg_ctrl_run) begin
                        rdAddr   <= '0;
                        last_idx <= last_sel;
                        mode32   <= reg_ctrl_32bit;
                        stop_req <= 1'b0;
                        aborted  <= 1'b0;
                        rdEn     <= 1'b1;
                        state    <= 1'b1;
                        fsm      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    stop_req <= stop_req | ~reg_ctrl_run;
                    fsm      <= S_LOAD;
                end
                S_LOAD: begin
                    stop_req <= stop_req | ~reg_ctrl_run;
                    shreg    <= rdData;
                    bit_cnt  <= 3'd7;
                    cnt      <= '0;
                    neoData  <= 1'b1;   // every bit period opens high
                    fsm      <= S_BIT;
                end
                S_BIT: begin
                    if (cnt != BIT_LAST) begin
                        stop_req <= stop_req | ~reg_ctrl_run;
                        cnt      <= cnt_inc;
                        neoData  <= (cnt_inc < th_cur);
                    end else begin
                        cnt      <= '0;
                        shreg    <= {shreg[6:0], 1'b0};
                        stop_req <= 1'b0;
                        if (stop_req || !reg_ctrl_run) begin
                            neoData <= 1'b0;
                            aborted <= 1'b1;
                            fsm     <= S_LATCH;
                        end else if (bit_cnt != 3'd0) begin
                            bit_cnt <= bit_cnt - 3'd1;
                            neoData <= 1'b1;
                        end else if (next_addr > last_idx) begin
                            neoData <= 1'b0;
                            fsm     <= S_LATCH;
                        end else begin
                            rdAddr  <= next_addr[AW-1:0];
                            rdEn    <= 1'b1;
                            neoData <= 1'b0;
                            fsm     <= S_FETCH;
                        end
                    end
                end
                S_LATCH: begin
                    if (cnt == RST_LAST) begin
                        cnt            <= '0;
                        state          <= 1'b0;
                        stream_sync_of <= ~aborted;
`ifdef ANTON_NEOPIXEL_STREAM_FRAME_COUNT_EN
                        if (!aborted) frameCount <= frameCount + 16'd1;
`endif
                        fsm            <= S_DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_DONE: begin
                    dead <= 1'b1;
                    fsm  <= S_IDLE;
                end
                default: begin
                    state <= 1'b0;
                    fsm   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_anton_neopixel_stream_ctrl.sv
// Bench for anton_neopixel_stream_ctrl with short timing
// (T0H=2, T1H=4, BIT=6, RESET=10, BUFFER_END=7).
// A negedge monitor logs read addresses, rising edges, high widths and sync
// pulses; frame vectors come from a table, corner cases are hand sequences.

module tb_anton_neopixel_stream_ctrl;

    logic        busClk = 1'b0;
    logic        busReset;
    logic [12:0] reg_max;
    logic        reg_ctrl_run, reg_ctrl_limit, reg_ctrl_32bit;
    logic [2:0]  rdAddr;
    logic        rdEn;
    logic [7:0]  rdData;
    logic        neoData, stream_sync_of, state;
`ifdef ANTON_NEOPIXEL_STREAM_FRAME_COUNT_EN
    logic [15:0] frameCount;
`endif

    anton_neopixel_stream_ctrl #(
        .BUFFER_END(7), .CYCLES_T0H(2), .CYCLES_T1H(4),
        .CYCLES_BIT(6), .CYCLES_RESET(10)
    ) dut (
        .busClk(busClk), .busReset(busReset), .reg_max(reg_max),
        .reg_ctrl_run(reg_ctrl_run), .reg_ctrl_limit(reg_ctrl_limit),
        .reg_ctrl_32bit(reg_ctrl_32bit), .rdAddr(rdAddr), .rdEn(rdEn),
        .rdData(rdData), .neoData(neoData), .stream_sync_of(stream_sync_of),
        .state(state)
`ifdef ANTON_NEOPIXEL_STREAM_FRAME_COUNT_EN
        , .frameCount(frameCount)
`endif
    );

    always #5 busClk = ~busClk;

    // pixel buffer with one cycle of read latency
    logic [7:0] mem [8];
    always @(posedge busClk) if (rdEn) rdData <= mem[rdAddr];

    int cyc = 0;
    always @(posedge busClk) cyc <= cyc + 1;

    int rise_q[$], hi_q[$], rd_q[$], rd_cyc_q[$], sync_q[$];
    int hi_run = 0;
    logic neo_prev = 1'b0;

    always @(negedge busClk) begin
        if (neoData && !neo_prev) rise_q.push_back(cyc);
        if (neoData) hi_run = hi_run + 1;
        if (!neoData && neo_prev) begin
            hi_q.push_back(hi_run);
            hi_run = 0;
        end
        if (rdEn) begin
            rd_q.push_back(int'(rdAddr));
            rd_cyc_q.push_back(cyc);
        end
        if (stream_sync_of) sync_q.push_back(cyc);
        neo_prev = neoData;
    end

    int n_cmp = 0;
    int n_err = 0;
    int fc_exp = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge busClk);
        #1;
    endtask

    task automatic clear_logs();
        rise_q.delete(); hi_q.delete(); rd_q.delete();
        rd_cyc_q.delete(); sync_q.delete();
    endtask

    task automatic wait_sync(input int n, input int budget);
        int b = budget;
        while (sync_q.size() < n && b > 0) begin
            tick();
            b--;
        end
        chk("sync_timeout", (sync_q.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        int b = budget;
        while (state !== 1'b0 && b > 0) begin
            tick();
            b--;
        end
        chk("idle_timeout", int'(state), 0);
    endtask

    typedef struct {
        string      nm;
        logic       limit;
        logic       b32;
        logic [12:0] rmax;
        logic [7:0] bufd [8];
        int         n;
        int         addrs [8];
    } vec_t;

    vec_t vt [5];

    task automatic run_vec(input vec_t v);
        logic [7:0] b;
        int exp_w;
        for (int i = 0; i < 8; i++) mem[i] = v.bufd[i];
        reg_ctrl_limit = v.limit;
        reg_ctrl_32bit = v.b32;
        reg_max        = v.rmax;
        clear_logs();
        reg_ctrl_run = 1'b1;
        wait_sync(1, 3000);
        reg_ctrl_run = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        fc_exp++;

        chk({v.nm, "_n_reads"}, rd_q.size(), v.n);
        for (int k = 0; k < rd_q.size() && k < v.n; k++)
            chk({v.nm, "_rd_addr"}, rd_q[k], v.addrs[k]);
        chk({v.nm, "_n_bits"}, hi_q.size(), v.n * 8);
        for (int j = 0; j < hi_q.size() && j < v.n * 8; j++) begin
            b = v.bufd[v.addrs[j / 8]];
            exp_w = b[7 - (j % 8)] ? 4 : 2;
            chk({v.nm, "_high_time"}, hi_q[j], exp_w);
        end
        for (int j = 1; j < rise_q.size(); j++)
            chk({v.nm, "_bit_period"}, rise_q[j] - rise_q[j-1], (j % 8 == 0) ? 8 : 6);
        if (rise_q.size() > 0 && rd_cyc_q.size() > 0)
            chk({v.nm, "_first_rise_lat"}, rise_q[0] - rd_cyc_q[0], 2);
        if (rise_q.size() > 0 && sync_q.size() > 0)
            chk({v.nm, "_latch_len"}, sync_q[0] - rise_q[rise_q.size()-1], 16);
        chk({v.nm, "_sync_cnt"}, sync_q.size(), 1);
        chk({v.nm, "_state_end"}, int'(state), 0);
`ifdef ANTON_NEOPIXEL_STREAM_FRAME_COUNT_EN
        chk({v.nm, "_frameCount"}, int'(frameCount), fc_exp);
`endif
    endtask

    int r0, s1, b;

    initial begin
        vt[0].nm = "one_byte";  vt[0].limit = 1; vt[0].b32 = 0; vt[0].rmax = 13'd0;
        vt[0].bufd = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[0].n = 1; vt[0].addrs = '{0, 0, 0, 0, 0, 0, 0, 0};

        vt[1].nm = "rgbw_full"; vt[1].limit = 0; vt[1].b32 = 1; vt[1].rmax = 13'd0;
        vt[1].bufd = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        vt[1].n = 6; vt[1].addrs = '{0, 1, 2, 4, 5, 6, 0, 0};

        vt[2].nm = "clamped";   vt[2].limit = 1; vt[2].b32 = 0; vt[2].rmax = 13'd100;
        vt[2].bufd = '{8'hFF, 8'h80, 8'h01, 8'h3C, 8'hC3, 8'h55, 8'hAA, 8'h0F};
        vt[2].n = 8; vt[2].addrs = '{0, 1, 2, 3, 4, 5, 6, 7};

        vt[3].nm = "rgbw_ch3";  vt[3].limit = 1; vt[3].b32 = 1; vt[3].rmax = 13'd3;
        vt[3].bufd = '{8'h81, 8'h42, 8'h24, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[3].n = 3; vt[3].addrs = '{0, 1, 2, 0, 0, 0, 0, 0};

        vt[4].nm = "limit5";    vt[4].limit = 1; vt[4].b32 = 0; vt[4].rmax = 13'd5;
        vt[4].bufd = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        vt[4].n = 6; vt[4].addrs = '{0, 1, 2, 3, 4, 5, 0, 0};

        busReset = 1'b1; reg_ctrl_run = 1'b0; reg_ctrl_limit = 1'b0;
        reg_ctrl_32bit = 1'b0; reg_max = '0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        tick(); tick();
        chk("rst_rdAddr", int'(rdAddr), 0);
        chk("rst_rdEn", int'(rdEn), 0);
        chk("rst_neoData", int'(neoData), 0);
        chk("rst_sync", int'(stream_sync_of), 0);
        chk("rst_state", int'(state), 0);
`ifdef ANTON_NEOPIXEL_STREAM_FRAME_COUNT_EN
        chk("rst_frameCount", int'(frameCount), 0);
`endif
        busReset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_vec(vt[i]);

        // abort: drop run inside the 3rd bit of byte 0
        mem[0] = 8'hA5; reg_ctrl_limit = 0; reg_ctrl_32bit = 0;
        clear_logs();
        reg_ctrl_run = 1'b1;
        b = 50;
        while (rise_q.size() == 0 && b > 0) begin tick(); b--; end
        chk("abort_start", (rise_q.size() > 0) ? 1 : 0, 1);
        r0 = (rise_q.size() > 0) ? rise_q[0] : cyc;
        while (cyc < r0 + 13) tick();
        reg_ctrl_run = 1'b0;
        while (cyc < r0 + 17) tick();
        chk("abort_bit2_low", int'(neoData), 0);
        tick();
        chk("abort_latch_low", int'(neoData), 0);
        chk("abort_latch_state", int'(state), 1);
        while (cyc < r0 + 27) tick();
        chk("abort_latch_end_state", int'(state), 1);
        tick();
        chk("abort_done_state", int'(state), 0);
        for (int i = 0; i < 6; i++) tick();
        chk("abort_rises", rise_q.size(), 3);
        chk("abort_reads", rd_q.size(), 1);
        chk("abort_no_sync", sync_q.size(), 0);
`ifdef ANTON_NEOPIXEL_STREAM_FRAME_COUNT_EN
        chk("abort_frameCount", int'(frameCount), fc_exp);
`endif

        // loop: run held across DONE, single-byte frames
        reg_ctrl_limit = 1; reg_max = 13'd0;
        clear_logs();
        reg_ctrl_run = 1'b1;
        wait_sync(1, 200);
        s1 = (sync_q.size() > 0) ? sync_q[0] : cyc;
        tick();
        chk("loop_dead_state", int'(state), 0);
        chk("loop_dead_rdEn", int'(rdEn), 0);
        tick();
        chk("loop_sample_rdEn", int'(rdEn), 0);
        tick();
        chk("loop_fetch_rdEn", int'(rdEn), 1);
        chk("loop_fetch_addr", int'(rdAddr), 0);
        chk("loop_fetch_state", int'(state), 1);
        chk("loop_fetch_cycle", cyc - s1, 3);
`ifdef ANTON_NEOPIXEL_STREAM_FRAME_COUNT_EN
        chk("loop_frameCount1", int'(frameCount), fc_exp + 1);
`endif
        wait_sync(2, 200);
        reg_ctrl_run = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("loop_syncs", sync_q.size(), 2);
        chk("loop_reads", rd_q.size(), 2);
        fc_exp += 2;
`ifdef ANTON_NEOPIXEL_STREAM_FRAME_COUNT_EN
        chk("loop_frameCount2", int'(frameCount), fc_exp);
`endif

        // synchronous reset in the middle of a bit
        reg_ctrl_limit = 0;
        clear_logs();
        reg_ctrl_run = 1'b1;
        b = 50;
        while (rise_q.size() == 0 && b > 0) begin tick(); b--; end
        chk("rst_mid_start", (rise_q.size() > 0) ? 1 : 0, 1);
        tick();
        busReset = 1'b1;
        tick();
        chk("rst_mid_neoData", int'(neoData), 0);
        chk("rst_mid_state", int'(state), 0);
        chk("rst_mid_rdEn", int'(rdEn), 0);
        chk("rst_mid_rdAddr", int'(rdAddr), 0);
        tick();
        busReset = 1'b0;
        clear_logs();
        b = 10;
        while (rd_q.size() == 0 && b > 0) begin tick(); b--; end
        chk("rst_restart_read", (rd_q.size() > 0) ? 1 : 0, 1);
        if (rd_q.size() > 0) chk("rst_restart_addr", rd_q[0], 0);
        reg_ctrl_run = 1'b0;
        wait_idle(100);
        for (int i = 0; i < 4; i++) tick();
        chk("rst_restart_no_sync", sync_q.size(), 0);
`ifdef ANTON_NEOPIXEL_STREAM_FRAME_COUNT_EN
        chk("rst_frameCount", int'(frameCount), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
